// File: rtl/clause_array_pkg.sv
// Shared types and constants for the clause array and its bin-level load/store sequencer.
// Includes the one-hot slot decoder used for both write and read strobes.
package clause_array_pkg;

  localparam int NUM_CLAUSES  = 8;
  localparam int NUM_VARS     = 8;
  localparam int WIDTH_C_LEN  = 4;
  localparam int WIDTH_CLAUSE = NUM_VARS * 2;
  localparam int WIDTH_CNT    = $clog2(NUM_CLAUSES + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CLEAR,
    ST_RD,
    ST_CAP,
    ST_OUT
  } state_t;

  function automatic logic [NUM_CLAUSES-1:0] onehot(input logic [WIDTH_CNT-1:0] idx);
    logic [NUM_CLAUSES-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_CLAUSES; i++) begin
      if (idx == WIDTH_CNT'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/clause_bin_ctrl.sv
// Load/store sequencer between the bin memory controller and the clause array.
// state | meaning: IDLE wait | LOAD accept clauses | CLEAR zero unused slots | RD strobe read | CAP capture | OUT hold for consumer
module clause_bin_ctrl
  import clause_array_pkg::*;
(
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               load_start_i,
  input  logic [WIDTH_CNT-1:0]               load_num_i,
  input  logic                               store_start_i,
  input  logic [WIDTH_CLAUSE-1:0]            in_clause_i,
  input  logic [WIDTH_C_LEN-1:0]             in_len_i,
  input  logic                               in_valid_i,
  output logic                               in_ready_o,
  output logic [WIDTH_CLAUSE-1:0]            out_clause_o,
  output logic [WIDTH_C_LEN-1:0]             out_len_o,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic [NUM_CLAUSES-1:0]             wr_o,
  output logic [NUM_CLAUSES-1:0]             rd_o,
  output logic [WIDTH_CLAUSE-1:0]            arr_clause_o,
  output logic [WIDTH_C_LEN-1:0]             arr_len_o,
  input  logic [WIDTH_CLAUSE-1:0]            arr_clause_i,
  input  logic [WIDTH_C_LEN*NUM_CLAUSES-1:0] arr_len_i,
  output logic                               busy_o,
  output logic                               done_o,
  output logic [WIDTH_CNT-1:0]               loaded_cnt_o
);

  state_t                  r_state, w_state_nxt;
  logic [WIDTH_CNT-1:0]    r_slot, w_slot_nxt;
  logic [WIDTH_CNT-1:0]    r_loaded_cnt, w_loaded_cnt_nxt;
  logic [NUM_CLAUSES-1:0]  r_wr, w_wr_nxt;
  logic [NUM_CLAUSES-1:0]  r_rd, w_rd_nxt;
  logic [WIDTH_CLAUSE-1:0] r_arr_clause, w_arr_clause_nxt;
  logic [WIDTH_C_LEN-1:0]  r_arr_len, w_arr_len_nxt;
  logic [WIDTH_CLAUSE-1:0] r_out_clause, w_out_clause_nxt;
  logic [WIDTH_C_LEN-1:0]  r_out_len, w_out_len_nxt;
  logic                    r_out_valid, w_out_valid_nxt;
  logic                    r_done, w_done_nxt;

  logic [WIDTH_CNT-1:0]    w_load_n;
  logic [WIDTH_CNT-1:0]    w_last_slot;
  logic [WIDTH_C_LEN-1:0]  w_slot_len;

  assign w_load_n    = (load_num_i > WIDTH_CNT'(NUM_CLAUSES)) ? WIDTH_CNT'(NUM_CLAUSES) : load_num_i;
  assign w_last_slot = r_loaded_cnt - WIDTH_CNT'(1);
  assign w_slot_len  = arr_len_i[int'(r_slot)*WIDTH_C_LEN +: WIDTH_C_LEN];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_slot       <= '0;
      r_loaded_cnt <= '0;
      r_wr         <= '0;
      r_rd         <= '0;
      r_arr_clause <= '0;
      r_arr_len    <= '0;
      r_out_clause <= '0;
      r_out_len    <= '0;
      r_out_valid  <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_slot       <= w_slot_nxt;
      r_loaded_cnt <= w_loaded_cnt_nxt;
      r_wr         <= w_wr_nxt;
      r_rd         <= w_rd_nxt;
      r_arr_clause <= w_arr_clause_nxt;
      r_arr_len    <= w_arr_len_nxt;
      r_out_clause <= w_out_clause_nxt;
      r_out_len    <= w_out_len_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_done       <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_slot_nxt       = r_slot;
    w_loaded_cnt_nxt = r_loaded_cnt;
    w_wr_nxt         = '0;
    w_rd_nxt         = '0;
    w_arr_clause_nxt = r_arr_clause;
    w_arr_len_nxt    = r_arr_len;
    w_out_clause_nxt = r_out_clause;
    w_out_len_nxt    = r_out_len;
    w_out_valid_nxt  = r_out_valid;
    w_done_nxt       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (load_start_i) begin
          w_loaded_cnt_nxt = w_load_n;
          w_slot_nxt       = '0;
          w_state_nxt      = (w_load_n == '0) ? ST_CLEAR : ST_LOAD;
        end else if (store_start_i) begin
          w_slot_nxt = '0;
          if (r_loaded_cnt == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_rd_nxt    = onehot(WIDTH_CNT'(0));
            w_state_nxt = ST_RD;
          end
        end
      end
      ST_LOAD: begin
        if (in_valid_i) begin
          w_arr_clause_nxt = in_clause_i;
          w_arr_len_nxt    = in_len_i;
          w_wr_nxt         = onehot(r_slot);
          w_slot_nxt       = r_slot + WIDTH_CNT'(1);
          if (r_slot == w_last_slot) begin
            if (r_loaded_cnt < WIDTH_CNT'(NUM_CLAUSES)) begin
              w_state_nxt = ST_CLEAR;
            end else begin
              w_state_nxt = ST_IDLE;
              w_done_nxt  = 1'b1;
            end
          end
        end
      end
      ST_CLEAR: begin
        w_arr_clause_nxt = '0;
        w_arr_len_nxt    = '0;
        w_wr_nxt         = onehot(r_slot);
        w_slot_nxt       = r_slot + WIDTH_CNT'(1);
        if (r_slot == WIDTH_CNT'(NUM_CLAUSES - 1)) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      ST_RD: begin
        w_state_nxt = ST_CAP;
      end
      ST_CAP: begin
        // array read data is valid one cycle after the rd strobe
        w_out_clause_nxt = arr_clause_i;
        w_out_len_nxt    = w_slot_len;
        w_out_valid_nxt  = 1'b1;
        w_state_nxt      = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready_i) begin
          w_out_valid_nxt = 1'b0;
          if (r_slot == w_last_slot) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_slot_nxt  = r_slot + WIDTH_CNT'(1);
            w_rd_nxt    = onehot(r_slot + WIDTH_CNT'(1));
            w_state_nxt = ST_RD;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign in_ready_o   = (r_state == ST_LOAD);
  assign busy_o       = (r_state != ST_IDLE);
  assign done_o       = r_done;
  assign loaded_cnt_o = r_loaded_cnt;
  assign wr_o         = r_wr;
  assign rd_o         = r_rd;
  assign arr_clause_o = r_arr_clause;
  assign arr_len_o    = r_arr_len;
  assign out_clause_o = r_out_clause;
  assign out_len_o    = r_out_len;
  assign out_valid_o  = r_out_valid;

endmodule

// File: tb/tb_clause_bin_ctrl.sv
// Self-checking bench for clause_bin_ctrl: emulates the clause array and compares
// write/read/readback traffic against a slot-level model of what the bins should hold.
module tb_clause_bin_ctrl;
  import clause_array_pkg::*;

  localparam int NC   = NUM_CLAUSES;
  localparam int CW   = NUM_VARS * 2;
  localparam int LW   = WIDTH_C_LEN;
  localparam int CNTW = WIDTH_CNT;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            load_start_i = 1'b0;
  logic [CNTW-1:0] load_num_i = '0;
  logic            store_start_i = 1'b0;
  logic [CW-1:0]   in_clause_i = '0;
  logic [LW-1:0]   in_len_i = '0;
  logic            in_valid_i = 1'b0;
  logic            in_ready_o;
  logic [CW-1:0]   out_clause_o;
  logic [LW-1:0]   out_len_o;
  logic            out_valid_o;
  logic            out_ready_i = 1'b0;
  logic [NC-1:0]   wr_o, rd_o;
  logic [CW-1:0]   arr_clause_o;
  logic [LW-1:0]   arr_len_o;
  logic [CW-1:0]   arr_clause_i = '0;
  logic [LW*NC-1:0] arr_len_i = '0;
  logic            busy_o, done_o;
  logic [CNTW-1:0] loaded_cnt_o;

  always #5 clk = ~clk;

  clause_bin_ctrl dut (
    .clk(clk), .rst(rst),
    .load_start_i(load_start_i), .load_num_i(load_num_i), .store_start_i(store_start_i),
    .in_clause_i(in_clause_i), .in_len_i(in_len_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .out_clause_o(out_clause_o), .out_len_o(out_len_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .wr_o(wr_o), .rd_o(rd_o), .arr_clause_o(arr_clause_o), .arr_len_o(arr_len_o),
    .arr_clause_i(arr_clause_i), .arr_len_i(arr_len_i),
    .busy_o(busy_o), .done_o(done_o), .loaded_cnt_o(loaded_cnt_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {logic [NC-1:0] wr; logic [CW-1:0] c; logic [LW-1:0] l; logic d; int cyc;} wr_ev_t;
  typedef struct {logic [CW-1:0] c; logic [LW-1:0] l; int cyc;} out_ev_t;

  wr_ev_t        wr_q[$];
  logic [NC-1:0] rd_q[$];
  out_ev_t       out_q[$];
  logic [CW-1:0] mem_c[NC];
  logic [LW-1:0] mem_l[NC];
  int cyc = 0, done_cnt = 0, done_cyc = 0, hot_bad = 0, stall_bad = 0;
  logic          prev_stall = 1'b0;
  logic [CW-1:0] prev_c = '0;
  logic [LW-1:0] prev_l = '0;

  // clause array stand-in plus traffic recorder, sampled mid-cycle
  always @(negedge clk) begin
    cyc++;
    if (cyc == 1) begin
      for (int i = 0; i < NC; i++) begin
        mem_c[i] = CW'($urandom);
        mem_l[i] = LW'($urandom);
      end
    end
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if ((wr_o != 0 && rd_o != 0) || !$onehot0(wr_o) || !$onehot0(rd_o)) hot_bad++;
    if (wr_o != 0) begin
      wr_q.push_back('{wr_o, arr_clause_o, arr_len_o, done_o, cyc});
      for (int i = 0; i < NC; i++) if (wr_o[i]) begin
        mem_c[i] = arr_clause_o;
        mem_l[i] = arr_len_o;
      end
    end
    if (rd_o != 0) begin
      rd_q.push_back(rd_o);
      for (int i = 0; i < NC; i++) if (rd_o[i]) arr_clause_i = mem_c[i];
    end
    for (int i = 0; i < NC; i++) arr_len_i[i*LW +: LW] = mem_l[i];
    if (prev_stall && rst && (!out_valid_o || out_clause_o !== prev_c || out_len_o !== prev_l)) stall_bad++;
    prev_stall = rst && out_valid_o && !out_ready_i;
    prev_c = out_clause_o;
    prev_l = out_len_o;
    if (rst && out_valid_o && out_ready_i) out_q.push_back('{out_clause_o, out_len_o, cyc});
  end

  logic [CW-1:0] exp_c[NC];
  logic [LW-1:0] exp_l[NC];
  int            exp_cnt = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] all_outs();
    return {in_ready_o, out_clause_o, out_len_o, out_valid_o, wr_o, rd_o,
            arr_clause_o, arr_len_o, busy_o, done_o, loaded_cnt_o};
  endfunction

  task automatic do_load(input int n_req, input bit gaps, input bit with_store, input bit fixed, input string tag);
    int n, idx, budget, d0, first;
    bit hs, last;
    logic [CW-1:0] lc[NC];
    logic [LW-1:0] ll[NC];
    logic [NC-1:0] ew;
    n = (n_req > NC) ? NC : n_req;
    for (int i = 0; i < NC; i++) begin
      lc[i] = fixed ? CW'(i + 1) : CW'($urandom);
      ll[i] = fixed ? LW'(i + 1) : LW'($urandom_range(1, 15));
    end
    wr_q.delete();
    rd_q.delete();
    d0 = done_cnt;
    load_start_i = 1'b1;
    load_num_i = CNTW'(n_req);
    store_start_i = with_store;
    tick();
    load_start_i = 1'b0;
    store_start_i = 1'b0;
    idx = 0;
    budget = 0;
    while (done_cnt == d0 && budget < 100) begin
      in_valid_i = (idx < n) && (!gaps || $urandom_range(0, 1) == 1);
      in_clause_i = (idx < n) ? lc[idx] : CW'($urandom);
      in_len_i = (idx < n) ? ll[idx] : LW'($urandom);
      hs = in_valid_i && in_ready_o;
      last = hs && (idx == n - 1);
      store_start_i = with_store && in_ready_o && !last;
      tick();
      if (hs) idx++;
      budget++;
    end
    in_valid_i = 1'b0;
    store_start_i = 1'b0;
    tick();
    tick();
    chk({tag, "_no_timeout"}, budget < 100, 1);
    chk({tag, "_accepted"}, idx, n);
    chk({tag, "_nwrites"}, wr_q.size(), NC);
    for (int i = 0; i < NC; i++) begin
      if (i < wr_q.size()) begin
        ew = NC'(1) << i;
        chk($sformatf("%s_wr%0d", tag, i), {wr_q[i].wr, wr_q[i].c, wr_q[i].l, wr_q[i].d},
            {ew, (i < n) ? lc[i] : CW'(0), (i < n) ? ll[i] : LW'(0), i == NC - 1});
      end
    end
    first = gaps ? n : 0;
    if (first < NC && wr_q.size() == NC)
      chk({tag, "_consecutive"}, wr_q[NC-1].cyc - wr_q[first].cyc, NC - 1 - first);
    chk({tag, "_loaded_cnt"}, loaded_cnt_o, n);
    chk({tag, "_idle"}, {busy_o, in_ready_o}, 0);
    chk({tag, "_no_reads"}, rd_q.size(), 0);
    chk({tag, "_done_once"}, done_cnt - d0, 1);
    for (int i = 0; i < NC; i++) begin
      exp_c[i] = (i < n) ? lc[i] : '0;
      exp_l[i] = (i < n) ? ll[i] : '0;
    end
    exp_cnt = n;
  endtask

  task automatic do_store(input int mode, input string tag);
    int budget, d0;
    logic [NC-1:0] er;
    rd_q.delete();
    out_q.delete();
    wr_q.delete();
    d0 = done_cnt;
    store_start_i = 1'b1;
    tick();
    store_start_i = 1'b0;
    budget = 0;
    while (done_cnt == d0 && budget < 300) begin
      case (mode)
        0: out_ready_i = budget[0];
        1: out_ready_i = ($urandom_range(0, 2) == 0);
        default: out_ready_i = 1'b1;
      endcase
      tick();
      budget++;
    end
    out_ready_i = 1'b0;
    tick();
    tick();
    chk({tag, "_no_timeout"}, budget < 300, 1);
    chk({tag, "_nout"}, out_q.size(), exp_cnt);
    chk({tag, "_nrd"}, rd_q.size(), exp_cnt);
    for (int i = 0; i < exp_cnt; i++) begin
      if (i < out_q.size() && i < rd_q.size()) begin
        er = NC'(1) << i;
        chk($sformatf("%s_out%0d", tag, i), {rd_q[i], out_q[i].c, out_q[i].l}, {er, exp_c[i], exp_l[i]});
      end
    end
    if (out_q.size() > 0)
      chk({tag, "_done_after_hs"}, done_cyc - out_q[out_q.size()-1].cyc, 1);
    chk({tag, "_done_once"}, done_cnt - d0, 1);
    chk({tag, "_idle"}, {busy_o, out_valid_o}, 0);
    chk({tag, "_no_writes"}, wr_q.size(), 0);
    chk({tag, "_stable_stall"}, stall_bad, 0);
  endtask

  task automatic reset_check(input string tag);
    rst = 1'b0;
    #2;
    chk({tag, "_async_zero"}, all_outs(), 64'd0);
    tick();
    tick();
    rst = 1'b1;
    wr_q.delete();
    rd_q.delete();
    tick();
    tick();
    tick();
    tick();
    chk({tag, "_no_partial"}, wr_q.size() + rd_q.size(), 0);
    chk({tag, "_idle_after"}, {busy_o, loaded_cnt_o}, 0);
    exp_cnt = 0;
  endtask

  initial begin
    int budget;
    tick();
    tick();
    chk("reset_outputs", all_outs(), 64'd0);
    rst = 1'b1;
    tick();
    chk("post_reset_idle", all_outs(), 64'd0);

    do_load(8, 0, 0, 1, "load8_fixed");
    do_load(3, 0, 0, 0, "load3");
    do_store(0, "store3_toggle");
    do_load(0, 0, 0, 0, "load0");
    do_load(15, 0, 0, 0, "load15_sat");
    do_store(2, "store8");
    do_load(5, 1, 1, 0, "load5_prio_store");
    do_store(1, "store5_rand");

    for (int k = 0; k < 4; k++) begin
      do_load($urandom_range(0, 15), 1, 0, 0, $sformatf("rand_load%0d", k));
      do_store(1, $sformatf("rand_store%0d", k));
    end

    // abort in the middle of zero-clearing
    load_start_i = 1'b1;
    load_num_i = '0;
    tick();
    load_start_i = 1'b0;
    tick();
    tick();
    chk("clear_in_progress", busy_o, 1);
    reset_check("rst_clear");
    do_store(2, "store_empty");

    // abort while holding readback data
    do_load(3, 0, 0, 0, "load3b");
    store_start_i = 1'b1;
    tick();
    store_start_i = 1'b0;
    out_ready_i = 1'b0;
    budget = 0;
    while (!out_valid_o && budget < 20) begin
      tick();
      budget++;
    end
    chk("out_reached", out_valid_o, 1);
    reset_check("rst_out");

    chk("never_multihot", hot_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clause_bin_ctrl.md
# clause_bin_ctrl

Load/store sequencer for the clause array. It accepts a stream of clauses from the bin manager and writes them one per slot into the array via one-hot `wr_i`, zero-clearing any unused slots. On request, it reads every loaded slot back via one-hot `rd_i` and streams the clauses and lengths out. It sits between the bin-level memory controller and the top clause array instance. It is idle while the array is doing implication and backtracking.

## Interface
- NUM_CLAUSES, 8, clause slots in the array
- NUM_VARS, 8, variables per clause (2 bits each)
- WIDTH_C_LEN, 4, clause length width
- WIDTH_CNT, $clog2(NUM_CLAUSES+1), count width
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-low (0 = reset)
- load_start_i  in  1  start load, sampled in IDLE only
- load_num_i  in  WIDTH_CNT  clauses to load; values > NUM_CLAUSES saturate to NUM_CLAUSES
- store_start_i  in  1  start readback, sampled in IDLE only
- in_clause_i  in  NUM_VARS*2  incoming clause
- in_len_i  in  WIDTH_C_LEN  incoming clause length
- in_valid_i  in  1  incoming data valid
- in_ready_o  out  1  controller ready for incoming data
- out_clause_o  out  NUM_VARS*2  readback clause
- out_len_o  out  WIDTH_C_LEN  readback length
- out_valid_o  out  1  readback data valid
- out_ready_i  in  1  consumer ready for readback data
- wr_o  out  NUM_CLAUSES  one-hot slot write, to array `wr_i`
- rd_o  out  NUM_CLAUSES  one-hot slot read, to array `rd_i`
- arr_clause_o  out  NUM_VARS*2  write data, to array `clause_i`
- arr_len_o  out  WIDTH_C_LEN  write length, to array `clause_len_i`
- arr_clause_i  in  NUM_VARS*2  from array `clause_o`
- arr_len_i  in  WIDTH_C_LEN*NUM_CLAUSES  from array `clause_len_o`
- busy_o  out  1  not in IDLE
- done_o  out  1  one-cycle pulse at the end of a load or store
- loaded_cnt_o  out  WIDTH_CNT  number of valid clauses from the last load

## Operation
- States: IDLE, LOAD, CLEAR, RD, CAP, OUT.
- IDLE behaviour:
  - `load_start_i` has priority over `store_start_i` when both are asserted.
  - Starts are ignored when the controller is not in IDLE.
  - Entering a command sets `slot` to 0.
- LOAD:
  - `in_ready_o` = 1.
  - On each handshake, the clause and length are registered into `arr_*_o` and `wr_o` = onehot(slot) on the next cycle, for 1 cycle.
  - `slot` increments on each handshake.
  - After accepting clause n-1 (n = saturated `load_num_i`): go to CLEAR if n < NUM_CLAUSES, else finish.
  - n = 0 goes from IDLE straight to CLEAR.
  - `loaded_cnt_o` <= n when the load begins.
- CLEAR:
  - One slot per cycle: writes clause 0 with length 0 to each slot from n to NUM_CLAUSES-1.
  - Finish after slot NUM_CLAUSES-1.
- Store:
  - If `loaded_cnt_o` = 0: finish immediately.
  - RD: `rd_o` = onehot(slot) for 1 cycle.
  - CAP: capture `arr_clause_i` and `arr_len_i[slot*WIDTH_C_LEN +: WIDTH_C_LEN]` into `out_*_o`, set `out_valid_o`.
  - OUT: hold `out_*_o` stable until `out_ready_i`. Then, if slot = cnt-1, finish; else slot++ and go to RD.
- Finish: `done_o` = 1 for 1 cycle, return to IDLE.
- `wr_o` and `rd_o` are never nonzero in the same cycle and are never multi-hot.

## Timing
- Reset values: all outputs 0. State IDLE, `slot` 0, `loaded_cnt_o` 0.
- Reset mid-operation aborts immediately. No partial write is issued after reset deasserts.
- Load throughput: 1 clause/cycle. `wr_o` lags the handshake by 1 cycle.
- The final write (last data or last clear) and `done_o` appear in the same cycle.
- The array read is 1-cycle: `arr_*_i` are valid in the cycle after `rd_o`.
- Store throughput: 3 cycles per clause minimum (RD, CAP, OUT). Back-pressure extends OUT without limit.
- `done_o` is asserted in the cycle after the final OUT handshake.
- `in_valid_i` outside LOAD is ignored. `in_ready_o` is 0 outside LOAD.

## Structure
- Shared package `clause_array_pkg`:
  - state enum
  - WIDTH_CNT derivation
  - onehot-decode function, shared with `clause_bin_ctrl`'s wr/rd generation
- No sub-module: the FSM, slot counter and output registers fit in one module.

## Test plan
- Reset, then load n=8 with back-to-back valid clauses 0x0001…0x0008, lengths 1…8 -> `wr_o` = 0x01…0x80 on consecutive cycles; `done_o` with the last write; `loaded_cnt_o` = 8.
- Load n=3 -> 3 data writes, then 5 clear writes (`wr_o` 0x08…0x80, data 0, length 0); `done_o` with the 0x80 write.
- Load n=0 and n=15 -> 8 clear writes; saturation to 8 data writes.
- Store after the n=3 load, with `out_ready_i` toggling every other cycle -> exactly 3 outputs in slot order with correct length slices; outputs stable while stalled; `rd_o` one-hot 0x01, 0x02, 0x04.
- `load_start_i` and `store_start_i` together in IDLE -> load runs. `store_start_i` during LOAD -> ignored.
- Reset asserted during CLEAR and during OUT -> all outputs 0 asynchronously; IDLE after release; `loaded_cnt_o` = 0.
